// File: rtl/cpu_test_sequencer.sv
// rtl/cpu_test_sequencer.sv - boot/test sequencer: load imem, preload dmem, run core, dump dmem
module cpu_test_sequencer #(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10,
    parameter int CYC_W   = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 start,
    input  logic [IMEM_AW:0]     imem_len,
    input  logic [DMEM_AW:0]     dmem_len,
    input  logic [DMEM_AW:0]     dump_len,
    input  logic [CYC_W-1:0]     run_cycles,
    input  logic                 in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [63:0]          out_data,
    input  logic                 out_ready,
    output logic                 cpu_enable,
    output logic [63:0]          addr_ext,
    output logic                 wen_ext,
    output logic                 ren_ext,
    output logic [31:0]          wdata_ext,
    output logic [63:0]          addr_ext_2,
    output logic                 wen_ext_2,
    output logic                 ren_ext_2,
    output logic [63:0]          wdata_ext_2,
    input  logic [63:0]          rdata_ext_2,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;

    // Encoding order matters: phase skipping relies on later phases having larger codes.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_I   = 3'd1;
    localparam logic [2:0] S_LOAD_D   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DUMP_RD  = 3'd4;
    localparam logic [2:0] S_DUMP_OUT = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]         state;
    logic [IW-1:0]      idx;
    logic [IMEM_AW:0]   i_len;
    logic [DMEM_AW:0]   d_len;
    logic [DMEM_AW:0]   u_len;
    logic [CYC_W-1:0]   r_len;
    logic [CYC_W-1:0]   cyc;
    logic [IW-1:0]      i_last;
    logic [IW-1:0]      d_last;
    logic [IW-1:0]      u_last;

    function automatic logic [2:0] after_phase(input logic [2:0] from, input logic i_nz,
                                               input logic d_nz, input logic r_nz, input logic u_nz);
        logic [2:0] nxt;
        nxt = S_DONE;
        if (u_nz && from < S_DUMP_RD) nxt = S_DUMP_RD;
        if (r_nz && from < S_RUN)     nxt = S_RUN;
        if (d_nz && from < S_LOAD_D)  nxt = S_LOAD_D;
        if (i_nz && from < S_LOAD_I)  nxt = S_LOAD_I;
        return nxt;
    endfunction

    assign i_last = IW'(i_len) - IW'(1);
    assign d_last = IW'(d_len) - IW'(1);
    assign u_last = IW'(u_len) - IW'(1);

    assign in_ready    = (state == S_LOAD_I) || (state == S_LOAD_D);
    assign cpu_enable  = (state == S_RUN);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);

    assign wen_ext     = (state == S_LOAD_I) && in_valid;
    assign ren_ext     = 1'b0;
    assign addr_ext    = (state == S_LOAD_I) ? 64'({idx, 2'b00}) : 64'd0;
    assign wdata_ext   = (state == S_LOAD_I) ? in_data[31:0] : 32'd0;

    assign wen_ext_2   = (state == S_LOAD_D) && in_valid;
    assign ren_ext_2   = (state == S_DUMP_RD);
    assign addr_ext_2  = ((state == S_LOAD_D) || (state == S_DUMP_RD)) ? 64'({idx, 3'b000}) : 64'd0;
    assign wdata_ext_2 = (state == S_LOAD_D) ? in_data : 64'd0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            i_len     <= '0;
            d_len     <= '0;
            u_len     <= '0;
            r_len     <= '0;
            cyc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        i_len <= imem_len;
                        d_len <= dmem_len;
                        u_len <= dump_len;
                        r_len <= run_cycles;
                        idx   <= '0;
                        cyc   <= '0;
                        state <= after_phase(S_IDLE, imem_len != '0, dmem_len != '0,
                                             run_cycles != '0, dump_len != '0);
                    end
                end
                S_LOAD_I: begin
                    if (in_valid) begin
                        if (idx == i_last) begin
                            idx   <= '0;
                            state <= after_phase(S_LOAD_I, 1'b1, d_len != '0, r_len != '0, u_len != '0);
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_LOAD_D: begin
                    if (in_valid) begin
                        if (idx == d_last) begin
                            idx   <= '0;
                            state <= after_phase(S_LOAD_D, 1'b0, 1'b1, r_len != '0, u_len != '0);
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (cyc == r_len - CYC_W'(1)) begin
                        cyc   <= '0;
                        idx   <= '0;
                        state <= after_phase(S_RUN, 1'b0, 1'b0, 1'b1, u_len != '0);
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                S_DUMP_RD: state <= S_DUMP_OUT;
                S_DUMP_OUT: begin
                    // First cycle here the SRAM read data is valid; capture it before raising out_valid.
                    if (!out_valid) begin
                        out_data  <= rdata_ext_2;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == u_last) begin
                            idx   <= '0;
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= S_DUMP_RD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
